seq_match_ctrl: RTL and testbench
=================================

# seq_match_ctrl

Run controller for serial pattern detection. It holds a programmable pattern of up to PAT_W bits, gates a serial bit stream through a start/stop run handshake, and raises a registered Mealy-style match pulse for each occurrence. It counts matches and signals completion when a programmed target count is reached. It sits between a software-visible config port and the serial datapath, replacing hard-wired fixed-pattern detectors.

## Interface
- PAT_W, 4: maximum pattern length in bits (≥2).
- LEN_W, $clog2(PAT_W+1): width of `cfg_len`.
- CNT_W, 8: width of the match counter and target.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  load `cfg_pattern`/`cfg_len`. Accepted only in IDLE or DONE.
- cfg_pattern  in  PAT_W  pattern. Bit [len-1] is the first-received bit and bit [0] the last.
- cfg_len  in  LEN_W  pattern length. 0 or >PAT_W is stored as PAT_W.
- target  in  CNT_W  match count that ends a run. 0 means unbounded. Sampled on start.
- start  in  1  begin run (pulse).
- stop  in  1  abort run (pulse).
- data_valid  in  1  `data_in` is valid this cycle.
- data_in  in  1  serial bit.
- busy  out  1  high in RUN.
- match  out  1  one-cycle pulse per detected occurrence.
- match_cnt  out  CNT_W  matches in the current or last run.
- done  out  1  high in DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - start → RUN. Clears match_cnt, window fill count and shift window. Latches target.
  - cfg_we updates the stored config. If start and cfg_we are asserted together, config loads first and the run uses the new config.
- RUN:
  - Each cycle with data_valid=1 shifts data_in into the LSB of the PAT_W-bit window and increments fill, saturating at PAT_W.
  - Hit: fill (after the shift) ≥ len, and window[len-1:0] == pattern[len-1:0].
  - On a hit: match pulses, and match_cnt increments, saturating at all-ones.
  - If the target is nonzero and match_cnt+1 == target → DONE.
  - stop → IDLE. A bit presented in the stop cycle is discarded. stop has priority over a hit in the same cycle.
  - start is ignored in RUN. cfg_we is ignored in RUN.
- DONE:
  - done=1. match_cnt is held.
  - start → RUN with the same clearing as from IDLE.
  - stop → IDLE.
  - cfg_we is accepted.
- Reset values:
  - busy=0, match=0, match_cnt=0, done=0.
  - pattern=4'b1011 zero-extended, len=4, window=0, fill=0.
- Reset asserted mid-run aborts immediately. No match pulse is produced for partial windows.

## Timing
- match is registered. It asserts for exactly one cycle, in the cycle after the clock edge that sampled the completing bit. match_cnt updates on the same edge.
- busy rises one cycle after start is sampled. It falls one cycle after stop is sampled, or on the same edge that enters DONE.
- The final match and done assert together: done rises on the same edge as the last match pulse.
- Throughput is one bit per clock. Back-to-back hits produce back-to-back match pulses.
- data_valid=0 cycles do not shift the window and do not change the state.

## Configuration
- SEQ_OVERLAP_EN defined: overlapping detection. The window and fill are kept after a hit, so a suffix may begin the next occurrence.
- SEQ_OVERLAP_EN undefined: non-overlapping detection. On a hit, fill is cleared to 0 on the same edge, so the next occurrence needs len fresh bits.
- Both builds share identical ports and reset values.

## Test plan
- Default config, target=0, stream 1,0,1,1,0,1,1 (data_valid=1):
  - With SEQ_OVERLAP_EN: match pulses after bits 4 and 7, match_cnt=2.
  - Without SEQ_OVERLAP_EN: one pulse after bit 4, match_cnt=1.
- target=2, stream 1,0,1,1,1,0,1,1:
  - Pulses after bits 4 and 8.
  - done and busy=0 on the edge of the second pulse.
  - Subsequent bits are ignored and match_cnt holds at 2.
- cfg_we with pattern=3'b110, len=3 in IDLE, then stream 1,1,0,1,1,0 with overlap → pulses after bits 3 and 6.
  - A cfg_we with a different pattern issued during the run has no effect.
- Stream 1,0,_,1,_,1 with data_valid=0 at the "_" slots → exactly one pulse, after the final 1.
- Mid-run abort cases:
  - stop asserted with the completing bit of 1011 → no pulse, busy=0 next cycle.
  - rst_n low mid-window → all outputs 0 immediately, pattern back to 1011.
- cfg_len=0 loaded → stored len=PAT_W. Repeated start in DONE restarts with match_cnt=0.

Source files
------------

// File: rtl/seq_match_ctrl.sv
// ---------------------------------------------------------------------------
// seq_match_ctrl
//
// Run controller for a programmable serial pattern detector. A pattern of up
// to PAT_W bits, with its length, is loaded over the config port while the
// block is IDLE or DONE. A start pulse opens a run. During the run, valid
// serial bits shift through a PAT_W-bit window. Each occurrence of the pattern
// produces a registered one-cycle match pulse and bumps the match counter.
// The run finishes in DONE once a nonzero target count is reached, and stop
// aborts it back to IDLE.
//
// Build option:
//   SEQ_OVERLAP_EN  defined   -> overlapping detection (window kept on a hit)
//                   undefined -> non-overlapping detection (fill cleared on hit)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   cfg_we       load cfg_pattern / cfg_len (ignored while RUN)
//   cfg_pattern  pattern, bit [len-1] is received first, bit [0] last
//   cfg_len      pattern length, 0 or >PAT_W stored as PAT_W
//   target       match count that ends a run (0 = unbounded), sampled on start
//   start        begin a run (pulse)
//   stop         abort a run (pulse)
//   data_valid   data_in is valid this cycle
//   data_in      serial data bit
//   busy         high while RUN
//   match        one-cycle pulse per detected occurrence
//   match_cnt    matches in the current or last run (saturating)
//   done         high while DONE
// ---------------------------------------------------------------------------
module seq_match_ctrl #(
  parameter int PAT_W = 4,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] target,
  input  logic             start,
  input  logic             stop,
  input  logic             data_valid,
  input  logic             data_in,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Reset pattern 1011 zero-extended; a narrower build falls back to PAT_W.
  localparam logic [PAT_W-1:0] RST_PATTERN = PAT_W'(4'b1011);
  localparam logic [LEN_W-1:0] RST_LEN     = LEN_W'((PAT_W >= 4) ? 4 : PAT_W);
  localparam logic [LEN_W-1:0] MAX_LEN     = LEN_W'(PAT_W);

`ifdef SEQ_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  state_t           state, state_next;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [PAT_W-1:0] window;
  logic [LEN_W-1:0] fill;
  logic [CNT_W-1:0] target_q;

  logic             shift_en;
  logic             run_start;
  logic             cfg_load;
  logic [PAT_W-1:0] window_next;
  logic [LEN_W-1:0] fill_next;
  logic [PAT_W-1:0] len_mask;
  logic             hit;
  logic [CNT_W-1:0] cnt_inc;
  logic             reach_target;

  // Hit detection works on the post-shift window so the match pulse can be
  // registered on the same edge that samples the completing bit. A bit that
  // arrives together with stop is discarded, which also makes stop win over a
  // hit. The mask keeps only the low len bits; len == PAT_W shifts every one
  // out, leaving a full mask.
  always_comb begin
    shift_en     = (state == RUN) && data_valid && !stop;
    run_start    = (state != RUN) && start;
    cfg_load     = (state != RUN) && cfg_we;
    window_next  = {window[PAT_W-2:0], data_in};
    fill_next    = (fill == MAX_LEN) ? fill : fill + LEN_W'(1);
    len_mask     = ~({PAT_W{1'b1}} << len);
    hit          = shift_en && (fill_next >= len) &&
                   (((window_next ^ pattern) & len_mask) == '0);
    cnt_inc      = match_cnt + CNT_W'(1);
    reach_target = hit && (target_q != '0) && (cnt_inc == target_q);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. In DONE a simultaneous start wins over stop.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (stop)              state_next = IDLE;
        else if (reach_target) state_next = DONE;
      end
      DONE: begin
        if (start)     state_next = RUN;
        else if (stop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Config, window, counter and registered match pulse. Config loaded in the
  // same cycle as start is already in place when the first run bit arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern   <= RST_PATTERN;
      len       <= RST_LEN;
      window    <= '0;
      fill      <= '0;
      target_q  <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      match <= 1'b0;
      if (cfg_load) begin
        pattern <= cfg_pattern;
        len     <= ((cfg_len == '0) || (cfg_len > MAX_LEN)) ? MAX_LEN : cfg_len;
      end
      if (run_start) begin
        window    <= '0;
        fill      <= '0;
        match_cnt <= '0;
        target_q  <= target;
      end else if (shift_en) begin
        window <= window_next;
        fill   <= (hit && !OVERLAP) ? '0 : fill_next;
        if (hit) begin
          match     <= 1'b1;
          match_cnt <= (match_cnt == '1) ? match_cnt : cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_match_ctrl
//
// Self-checking bench for seq_match_ctrl. A behavioural model keeps the run
// state and the list of bits received since the run began (or since the last
// hit when detection does not overlap) and decides hits by comparing the
// newest len bits against the pattern. Every expected match pulse goes into
// a scoreboard queue, and a separate negedge monitor pops entries when the
// DUT pulses match. Directed scenarios run first, then a randomized phase.
// Build with +define+SEQ_OVERLAP_EN to check the overlapping variant.
// ---------------------------------------------------------------------------
module tb_seq_match_ctrl;

  localparam int PAT_W  = 4;
  localparam int LEN_W  = $clog2(PAT_W + 1);
  localparam int CNT_W  = 8;
  localparam int MAXCNT = (1 << CNT_W) - 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  typedef struct {
    int cyc;
    int cnt;
    int dn;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [CNT_W-1:0] target;
  logic             start;
  logic             stop;
  logic             data_valid;
  logic             data_in;
  logic             busy;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  exp_t sb[$];

  // Reference model state
  int               m_state;
  logic [PAT_W-1:0] m_pattern;
  int               m_len;
  int               m_cnt;
  int               m_target;
  bit               m_bits[$];

  seq_match_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .target(target), .start(start), .stop(stop),
    .data_valid(data_valid), .data_in(data_in), .busy(busy), .match(match),
    .match_cnt(match_cnt), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: any expectation whose cycle has passed is a missed pulse;
  // a pulse with nothing queued is a spurious one.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checkOutput("missed_match_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (match) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_match", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("match_cycle", cyc, e.cyc);
          checkOutput("match_cnt_at_pulse", int'(match_cnt), e.cnt);
          checkOutput("done_at_pulse", int'(done), e.dn);
        end
      end
    end
  end

  task automatic modelReset();
    m_state   = M_IDLE;
    m_pattern = PAT_W'(4'b1011);
    m_len     = 4;
    m_cnt     = 0;
    m_target  = 0;
    m_bits.delete();
  endtask

  task automatic modelBeginRun(input int tg);
    m_state  = M_RUN;
    m_cnt    = 0;
    m_target = tg;
    m_bits.delete();
  endtask

  // One clock of stimulus: the model advances from the inputs, then after the
  // edge any expected pulse is queued and the status outputs are compared.
  task automatic applyStimulus(input logic s, input logic p, input logic cw,
                               input logic [PAT_W-1:0] cp, input logic [LEN_W-1:0] cl,
                               input logic [CNT_W-1:0] tg, input logic dv, input logic di);
    bit   hit;
    exp_t e;
    hit         = 1'b0;
    start       = s;
    stop        = p;
    cfg_we      = cw;
    cfg_pattern = cp;
    cfg_len     = cl;
    target      = tg;
    data_valid  = dv;
    data_in     = di;

    if (cw && m_state != M_RUN) begin
      m_pattern = cp;
      m_len     = (int'(cl) == 0 || int'(cl) > PAT_W) ? PAT_W : int'(cl);
    end
    case (m_state)
      M_IDLE: if (s) modelBeginRun(int'(tg));
      M_DONE: begin
        if (s)      modelBeginRun(int'(tg));
        else if (p) m_state = M_IDLE;
      end
      default: begin
        if (p) m_state = M_IDLE;
        else if (dv) begin
          m_bits.push_back(di);
          if (m_bits.size() >= m_len) begin
            hit = 1'b1;
            for (int i = 0; i < m_len; i++)
              if (m_bits[m_bits.size() - 1 - i] != m_pattern[i]) hit = 1'b0;
          end
          if (hit) begin
            if (m_cnt < MAXCNT) m_cnt++;
            if (m_target != 0 && m_cnt == m_target) m_state = M_DONE;
`ifndef SEQ_OVERLAP_EN
            m_bits.delete();
`endif
          end
          while (m_bits.size() > PAT_W) void'(m_bits.pop_front());
        end
      end
    endcase

    @(posedge clk);
    #1;
    if (hit) begin
      e.cyc = cyc;
      e.cnt = m_cnt;
      e.dn  = (m_state == M_DONE) ? 1 : 0;
      sb.push_back(e);
    end
    checkOutput("busy", int'(busy), (m_state == M_RUN) ? 1 : 0);
    checkOutput("done", int'(done), (m_state == M_DONE) ? 1 : 0);
    checkOutput("match_cnt", int'(match_cnt), m_cnt);
    start  = 1'b0;
    stop   = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, '0, '0, '0, 0, 0);
  endtask

  task automatic runStart(input logic [CNT_W-1:0] tg);
    applyStimulus(1, 0, 0, '0, '0, tg, 0, 0);
  endtask

  task automatic runStop();
    applyStimulus(0, 1, 0, '0, '0, '0, 0, 0);
  endtask

  // '1'/'0' are valid bits, '_' is a data_valid=0 cycle.
  task automatic streamBits(input string s);
    for (int i = 0; i < s.len(); i++)
      applyStimulus(0, 0, 0, '0, '0, '0, s[i] != "_", s[i] == "1");
  endtask

  // Asynchronous reset placed mid-cycle; outputs must clear at once.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_match", int'(match), 0);
    checkOutput("rst_match_cnt", int'(match_cnt), 0);
    checkOutput("rst_done", int'(done), 0);
    sb.delete();
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    cfg_we      = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    target      = '0;
    data_valid  = 1'b0;
    data_in     = 1'b0;
    modelReset();
    doReset();
    idleCycle();

    $display("[TB] default pattern, unbounded run");
    runStart(0);
    streamBits("1011011");
    runStop();

    $display("[TB] target of two ends the run");
    runStart(2);
    streamBits("10111011");
    streamBits("1011");
    runStop();

    $display("[TB] config loaded with start, ignored during run");
    applyStimulus(1, 0, 1, 4'b0110, 3'd3, '0, 0, 0);
    streamBits("110");
    applyStimulus(0, 0, 1, 4'b0001, 3'd2, '0, 1, 1);
    streamBits("10");
    streamBits("0101");
    runStop();

    $display("[TB] cfg_len zero and gaps in the stream");
    applyStimulus(0, 0, 1, 4'b1011, 3'd0, '0, 0, 0);
    runStart(0);
    streamBits("10_1_1");
    runStop();

    $display("[TB] stop together with the completing bit");
    runStart(0);
    streamBits("101");
    applyStimulus(0, 1, 0, '0, '0, '0, 1, 1);
    idleCycle();

    $display("[TB] reset mid-window restores the default pattern");
    applyStimulus(0, 0, 1, 4'b0011, 3'd2, '0, 0, 0);
    runStart(0);
    streamBits("10");
    doReset();
    runStart(0);
    streamBits("1011");
    runStop();

    $display("[TB] restart from DONE");
    runStart(1);
    streamBits("1011");
    streamBits("1");
    runStart(0);
    streamBits("1011");
    runStop();

    $display("[TB] randomized phase");
    for (int n = 0; n < 800; n++) begin
      int r;
      r = $urandom_range(0, 99);
      applyStimulus(r < 4, r >= 4 && r < 7, $urandom_range(0, 9) == 0,
                    PAT_W'($urandom), LEN_W'($urandom_range(0, 7)),
                    CNT_W'($urandom_range(0, 4)),
                    $urandom_range(0, 3) != 0, 1'($urandom));
    end

    for (int n = 0; n < 3; n++) idleCycle();
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
